// File: rtl/i2c_cmd_reg_bank_if.sv
// Bus between the I2C slave / fabric (master side) and the MClk register bank (slave side).
interface i2c_cmd_reg_bank_if;
    logic       I2C_Data_Ready;
    logic [7:0] I2C_Reg_Cmnd;
    logic [7:0] I2C_Wr_Data;
    logic       I2C_Op_Read;
    logic [7:0] Status_In;
    logic [7:0] Rd_Reg_Data;
    logic [7:0] Reg_Api;
    logic [7:0] Reg_Len;
    logic [7:0] Reg_Clip;
    logic       Cmd_Valid;
    logic       Cmd_Ready;
    logic [7:0] Cmd_Code;
    logic [7:0] Cmd_Len;
    logic [7:0] Cmd_Clip;
    logic       Cmd_Ovf;
    logic       Wr_Err;
    logic       Clr_Flags;

    modport slave (
        input  I2C_Data_Ready, I2C_Reg_Cmnd, I2C_Wr_Data, I2C_Op_Read, Status_In,
               Cmd_Ready, Clr_Flags,
        output Rd_Reg_Data, Reg_Api, Reg_Len, Reg_Clip, Cmd_Valid, Cmd_Code,
               Cmd_Len, Cmd_Clip, Cmd_Ovf, Wr_Err
    );

    modport master (
        output I2C_Data_Ready, I2C_Reg_Cmnd, I2C_Wr_Data, I2C_Op_Read, Status_In,
               Cmd_Ready, Clr_Flags,
        input  Rd_Reg_Data, Reg_Api, Reg_Len, Reg_Clip, Cmd_Valid, Cmd_Code,
               Cmd_Len, Cmd_Clip, Cmd_Ovf, Wr_Err
    );
endinterface

// File: rtl/i2c_cmd_reg_bank.sv
// MClk-domain register bank and command queue behind the I2C slave: flag synchroniser,
// one-action-per-pulse decode FSM, show-ahead command FIFO and registered read mux.
module i2c_cmd_reg_bank #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [7:0]  HDL_VERSION = 8'h04
) (
    input  logic                MClk,
    input  logic                Rst_n,
    i2c_cmd_reg_bank_if.slave   bus
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(SYNC_STAGES + 1);

    typedef struct packed {
        logic [7:0] code;
        logic [7:0] len;
        logic [7:0] clip;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, DECODE, WAIT_LOW} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          fill_cnt;
    logic                   armed;
    logic                   rdy_s;
    logic                   primed;

    state_t state_q, state_d;
    logic   wr_api, wr_len, wr_clip, wr_cmd, wr_bad;

    logic [7:0] reg_api, reg_len, reg_clip, reg_cmd;
    logic       push_q;
    cmd_t       push_data;

    cmd_t         mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic          empty, full, pop, push_ok, ovf_set;
    cmd_t          head;

    logic       ovf_q, err_q;
    logic [7:0] rd_q, rd_d;

    assign rdy_s  = sync_q[SYNC_STAGES-1];
    assign primed = (fill_cnt == CW'(SYNC_STAGES));

    // Flag synchroniser; armed only after rdy_s has been genuinely seen low, so a
    // pulse already high when reset releases is not treated as a new write.
    always_ff @(posedge MClk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync_q   <= '0;
            fill_cnt <= '0;
            armed    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.I2C_Data_Ready};
            if (!primed) fill_cnt <= fill_cnt + CW'(1);
            if (primed && !rdy_s) armed <= 1'b1;
        end
    end

    always_ff @(posedge MClk or negedge Rst_n) begin
        if (!Rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and single-cycle write decode.
    always_comb begin
        state_d = state_q;
        wr_api  = 1'b0;
        wr_len  = 1'b0;
        wr_clip = 1'b0;
        wr_cmd  = 1'b0;
        wr_bad  = 1'b0;
        case (state_q)
            IDLE:     if (rdy_s && armed) state_d = DECODE;
            DECODE: begin
                state_d = WAIT_LOW;
                if (!bus.I2C_Op_Read) begin
                    case (bus.I2C_Reg_Cmnd)
                        8'd0:    wr_api  = 1'b1;
                        8'd2:    wr_cmd  = 1'b1;
                        8'd4:    wr_len  = 1'b1;
                        8'd5:    wr_clip = 1'b1;
                        default: wr_bad  = 1'b1;
                    endcase
                end
            end
            WAIT_LOW: if (!rdy_s) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Control registers; command pushes are staged one cycle before reaching the FIFO.
    always_ff @(posedge MClk or negedge Rst_n) begin
        if (!Rst_n) begin
            reg_api   <= '0;
            reg_len   <= '0;
            reg_clip  <= '0;
            reg_cmd   <= '0;
            push_q    <= 1'b0;
            push_data <= '0;
        end else begin
            push_q <= wr_cmd;
            if (wr_api)  reg_api  <= bus.I2C_Wr_Data;
            if (wr_len)  reg_len  <= bus.I2C_Wr_Data;
            if (wr_clip) reg_clip <= bus.I2C_Wr_Data;
            if (wr_cmd) begin
                reg_cmd   <= bus.I2C_Wr_Data;
                push_data <= '{code: bus.I2C_Wr_Data, len: reg_len, clip: reg_clip};
            end
        end
    end

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop     = !empty && bus.Cmd_Ready;
    assign push_ok = push_q && (!full || pop);
    assign ovf_set = push_q && full && !pop;
    assign head    = mem[rptr[AW-1:0]];

    always_ff @(posedge MClk or negedge Rst_n) begin
        if (!Rst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wptr[AW-1:0]] <= push_data;
                wptr <= wptr + PW'(1);
            end
            if (pop) rptr <= rptr + PW'(1);
        end
    end

    // Sticky flags: a set in the same cycle as a clear takes priority.
    always_ff @(posedge MClk or negedge Rst_n) begin
        if (!Rst_n) begin
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ovf_q <= ovf_set || (ovf_q && !bus.Clr_Flags);
            err_q <= wr_bad  || (err_q && !bus.Clr_Flags);
        end
    end

    always_comb begin
        rd_d = 8'h00;
        case (bus.I2C_Reg_Cmnd)
            8'd0:    rd_d = reg_api;
            8'd1:    rd_d = HDL_VERSION;
            8'd2:    rd_d = reg_cmd;
            8'd3:    rd_d = bus.Status_In;
            8'd4:    rd_d = reg_len;
            8'd5:    rd_d = reg_clip;
            default: rd_d = 8'h00;
        endcase
    end

    always_ff @(posedge MClk or negedge Rst_n) begin
        if (!Rst_n) rd_q <= '0;
        else        rd_q <= rd_d;
    end

    assign bus.Rd_Reg_Data = rd_q;
    assign bus.Reg_Api     = reg_api;
    assign bus.Reg_Len     = reg_len;
    assign bus.Reg_Clip    = reg_clip;
    assign bus.Cmd_Valid   = !empty;
    assign bus.Cmd_Code    = head.code;
    assign bus.Cmd_Len     = head.len;
    assign bus.Cmd_Clip    = head.clip;
    assign bus.Cmd_Ovf     = ovf_q;
    assign bus.Wr_Err      = err_q;

endmodule

// File: tb/tb_i2c_cmd_reg_bank.sv
// Scoreboard bench for i2c_cmd_reg_bank: expected queue entries are pushed when writes
// are driven and popped when the DUT presents/hands off its queue head.
module tb_i2c_cmd_reg_bank;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    i2c_cmd_reg_bank_if bus();

    i2c_cmd_reg_bank #(.SYNC_STAGES(2), .FIFO_DEPTH(DEPTH), .HDL_VERSION(8'h04)) dut (
        .MClk  (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [23:0] exp_q[$];
    logic [23:0] exp_head;
    logic [7:0]  m_api = 8'h00, m_len = 8'h00, m_clip = 8'h00, m_last = 8'h00;
    logic        m_ovf = 1'b0, m_err = 1'b0;

    // Full write transaction: pulse long enough for decode, then wait for FSM to return to IDLE.
    task automatic wr(input logic [7:0] idx, input logic [7:0] data, input logic rd);
        @(negedge clk);
        bus.I2C_Reg_Cmnd   = idx;
        bus.I2C_Wr_Data    = data;
        bus.I2C_Op_Read    = rd;
        bus.I2C_Data_Ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        bus.I2C_Data_Ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        if (!rd) begin
            case (idx)
                8'd0: m_api = data;
                8'd4: m_len = data;
                8'd5: m_clip = data;
                8'd2: begin
                    m_last = data;
                    if (exp_q.size() < DEPTH) exp_q.push_back({data, m_len, m_clip});
                    else m_ovf = 1'b1;
                end
                default: m_err = 1'b1;
            endcase
        end
    endtask

    task automatic pulse_ready();
        @(negedge clk);
        bus.Cmd_Ready = 1'b1;
        @(negedge clk);
        bus.Cmd_Ready = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.Clr_Flags = 1'b1;
        @(negedge clk);
        bus.Clr_Flags = 1'b0;
        m_ovf = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic test_reset();
        #5;
        vectors++; if ({bus.Reg_Api, bus.Reg_Len, bus.Reg_Clip, bus.Rd_Reg_Data} !== 32'h0) begin
            miscompares++; $display("FAIL reset_regs: got %h expected %h", {bus.Reg_Api, bus.Reg_Len, bus.Reg_Clip, bus.Rd_Reg_Data}, 32'h0); end
        vectors++; if ({bus.Cmd_Valid, bus.Cmd_Ovf, bus.Wr_Err} !== 3'b000) begin
            miscompares++; $display("FAIL reset_flags: got %b expected 000", {bus.Cmd_Valid, bus.Cmd_Ovf, bus.Wr_Err}); end
        vectors++; if ({bus.Cmd_Code, bus.Cmd_Len, bus.Cmd_Clip} !== 24'h0) begin
            miscompares++; $display("FAIL reset_head: got %h expected 000000", {bus.Cmd_Code, bus.Cmd_Len, bus.Cmd_Clip}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic test_basic();
        wr(8'd4, 8'h20, 1'b0);
        wr(8'd5, 8'h03, 1'b0);
        wr(8'd2, 8'hA5, 1'b0);
        vectors++; if (bus.Reg_Len !== 8'h20) begin
            miscompares++; $display("FAIL basic_len: got %h expected 20", bus.Reg_Len); end
        vectors++; if (bus.Reg_Clip !== 8'h03) begin
            miscompares++; $display("FAIL basic_clip: got %h expected 03", bus.Reg_Clip); end
        vectors++; if (bus.Cmd_Valid !== 1'b1) begin
            miscompares++; $display("FAIL basic_valid: got %b expected 1", bus.Cmd_Valid); end
        exp_head = exp_q.pop_front();
        vectors++; if ({bus.Cmd_Code, bus.Cmd_Len, bus.Cmd_Clip} !== exp_head) begin
            miscompares++; $display("FAIL basic_head: got %h expected %h", {bus.Cmd_Code, bus.Cmd_Len, bus.Cmd_Clip}, exp_head); end
        pulse_ready();
        vectors++; if (bus.Cmd_Valid !== 1'b0) begin
            miscompares++; $display("FAIL basic_drained: got %b expected 0", bus.Cmd_Valid); end
    endtask

    task automatic test_latency_hold();
        // Level first sampled at the edge after the drive; update lands three edges after that.
        @(negedge clk);
        bus.I2C_Reg_Cmnd = 8'd5; bus.I2C_Wr_Data = 8'h5A; bus.I2C_Op_Read = 1'b0;
        bus.I2C_Data_Ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (bus.Reg_Clip !== m_clip) begin
            miscompares++; $display("FAIL latency_early: got %h expected %h", bus.Reg_Clip, m_clip); end
        @(posedge clk);
        #1;
        m_clip = 8'h5A;
        vectors++; if (bus.Reg_Clip !== m_clip) begin
            miscompares++; $display("FAIL latency_update: got %h expected %h", bus.Reg_Clip, m_clip); end
        @(negedge clk);
        bus.I2C_Data_Ready = 1'b0;
        repeat (4) @(posedge clk);

        @(negedge clk);
        bus.I2C_Reg_Cmnd = 8'd2; bus.I2C_Wr_Data = 8'h11;
        bus.I2C_Data_Ready = 1'b1;
        repeat (500) @(posedge clk);
        @(negedge clk);
        bus.I2C_Data_Ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        m_last = 8'h11;
        exp_q.push_back({8'h11, m_len, m_clip});
        exp_head = exp_q.pop_front();
        vectors++; if ({bus.Cmd_Valid, bus.Cmd_Code, bus.Cmd_Len, bus.Cmd_Clip} !== {1'b1, exp_head}) begin
            miscompares++; $display("FAIL hold_head: got %h expected %h", {bus.Cmd_Valid, bus.Cmd_Code, bus.Cmd_Len, bus.Cmd_Clip}, {1'b1, exp_head}); end
        pulse_ready();
        vectors++; if (bus.Cmd_Valid !== 1'b0) begin
            miscompares++; $display("FAIL hold_single_entry: got %b expected 0", bus.Cmd_Valid); end
    endtask

    task automatic test_overflow();
        for (int d = 1; d <= 5; d++) wr(8'd2, 8'(d), 1'b0);
        vectors++; if (bus.Cmd_Ovf !== m_ovf) begin
            miscompares++; $display("FAIL ovf_set: got %b expected %b", bus.Cmd_Ovf, m_ovf); end
        pulse_clear();
        vectors++; if (bus.Cmd_Ovf !== m_ovf) begin
            miscompares++; $display("FAIL ovf_clear: got %b expected %b", bus.Cmd_Ovf, m_ovf); end
        // Push of 06 reaches the full FIFO on the fifth edge; pop on that same edge.
        @(negedge clk);
        bus.I2C_Reg_Cmnd = 8'd2; bus.I2C_Wr_Data = 8'h06;
        bus.I2C_Data_Ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        exp_head = exp_q.pop_front();
        vectors++; if ({bus.Cmd_Code, bus.Cmd_Len, bus.Cmd_Clip} !== exp_head) begin
            miscompares++; $display("FAIL full_pushpop_head: got %h expected %h", {bus.Cmd_Code, bus.Cmd_Len, bus.Cmd_Clip}, exp_head); end
        bus.Cmd_Ready = 1'b1;
        @(negedge clk);
        bus.Cmd_Ready = 1'b0;
        m_last = 8'h06;
        exp_q.push_back({8'h06, m_len, m_clip});
        bus.I2C_Data_Ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        vectors++; if (bus.Cmd_Ovf !== 1'b0) begin
            miscompares++; $display("FAIL full_pushpop_ovf: got %b expected 0", bus.Cmd_Ovf); end
        while (exp_q.size() > 0) begin
            exp_head = exp_q.pop_front();
            vectors++; if ({bus.Cmd_Valid, bus.Cmd_Code, bus.Cmd_Len, bus.Cmd_Clip} !== {1'b1, exp_head}) begin
                miscompares++; $display("FAIL drain_head: got %h expected %h", {bus.Cmd_Valid, bus.Cmd_Code, bus.Cmd_Len, bus.Cmd_Clip}, {1'b1, exp_head}); end
            pulse_ready();
        end
        vectors++; if (bus.Cmd_Valid !== 1'b0) begin
            miscompares++; $display("FAIL drain_empty: got %b expected 0", bus.Cmd_Valid); end
    endtask

    task automatic test_wr_err();
        wr(8'd0, 8'h9C, 1'b0);
        wr(8'd1, 8'hFF, 1'b0);
        wr(8'd7, 8'h55, 1'b0);
        vectors++; if ({bus.Reg_Api, bus.Reg_Len, bus.Reg_Clip} !== {m_api, m_len, m_clip}) begin
            miscompares++; $display("FAIL err_regs: got %h expected %h", {bus.Reg_Api, bus.Reg_Len, bus.Reg_Clip}, {m_api, m_len, m_clip}); end
        vectors++; if ({bus.Wr_Err, bus.Cmd_Valid} !== {m_err, 1'b0}) begin
            miscompares++; $display("FAIL err_flag: got %b expected %b", {bus.Wr_Err, bus.Cmd_Valid}, {m_err, 1'b0}); end
        pulse_clear();
        wr(8'd0, 8'h77, 1'b1);
        vectors++; if ({bus.Reg_Api, bus.Wr_Err} !== {m_api, 1'b0}) begin
            miscompares++; $display("FAIL read_op_noact: got %h expected %h", {bus.Reg_Api, bus.Wr_Err}, {m_api, 1'b0}); end
    endtask

    task automatic test_read_mux();
        logic [7:0] e;
        bus.Status_In = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.I2C_Reg_Cmnd = 8'(i);
            case (i)
                0: e = m_api;
                1: e = 8'h04;
                2: e = m_last;
                3: e = 8'h3C;
                4: e = m_len;
                5: e = m_clip;
                default: e = 8'h00;
            endcase
            @(posedge clk);
            #1;
            vectors++; if (bus.Rd_Reg_Data !== e) begin
                miscompares++; $display("FAIL read_mux_%0d: got %h expected %h", i, bus.Rd_Reg_Data, e); end
        end
    endtask

    task automatic test_reset_mid();
        wr(8'd2, 8'hAA, 1'b0);
        wr(8'd2, 8'hBB, 1'b0);
        vectors++; if (bus.Cmd_Valid !== 1'b1) begin
            miscompares++; $display("FAIL mid_queued: got %b expected 1", bus.Cmd_Valid); end
        @(negedge clk);
        bus.I2C_Reg_Cmnd = 8'd2; bus.I2C_Wr_Data = 8'hCC;
        bus.I2C_Data_Ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        m_api = 8'h00; m_len = 8'h00; m_clip = 8'h00; m_last = 8'h00; m_ovf = 1'b0; m_err = 1'b0;
        vectors++; if ({bus.Cmd_Valid, bus.Reg_Api, bus.Reg_Len, bus.Reg_Clip, bus.Rd_Reg_Data, bus.Cmd_Code} !== 41'h0) begin
            miscompares++; $display("FAIL mid_reset_outputs: got %h expected 0", {bus.Cmd_Valid, bus.Reg_Api, bus.Reg_Len, bus.Reg_Clip, bus.Rd_Reg_Data, bus.Cmd_Code}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        vectors++; if ({bus.Cmd_Valid, bus.Rd_Reg_Data, bus.Wr_Err} !== {1'b0, m_last, 1'b0}) begin
            miscompares++; $display("FAIL release_high_noact: got %h expected %h", {bus.Cmd_Valid, bus.Rd_Reg_Data, bus.Wr_Err}, {1'b0, m_last, 1'b0}); end
        @(negedge clk);
        bus.I2C_Data_Ready = 1'b0;
        repeat (4) @(posedge clk);
        wr(8'd2, 8'hDD, 1'b0);
        exp_head = exp_q.pop_front();
        vectors++; if ({bus.Cmd_Valid, bus.Cmd_Code, bus.Cmd_Len, bus.Cmd_Clip} !== {1'b1, exp_head}) begin
            miscompares++; $display("FAIL rearm_head: got %h expected %h", {bus.Cmd_Valid, bus.Cmd_Code, bus.Cmd_Len, bus.Cmd_Clip}, {1'b1, exp_head}); end
        pulse_ready();
    endtask

    initial begin
        bus.I2C_Data_Ready = 1'b0;
        bus.I2C_Reg_Cmnd   = 8'h00;
        bus.I2C_Wr_Data    = 8'h00;
        bus.I2C_Op_Read    = 1'b0;
        bus.Status_In      = 8'h00;
        bus.Cmd_Ready      = 1'b0;
        bus.Clr_Flags      = 1'b0;
        test_reset();
        test_basic();
        test_latency_hold();
        test_overflow();
        test_wr_err();
        test_read_mux();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_cmd_reg_bank.md
Name: i2c_cmd_reg_bank

Overview:
- MClk-domain register bank and command queue directly downstream of the I2C slave.
- Consumes the slave's SCL-domain write-complete flag, register index and data byte, and synchronises the flag into MClk.
- Maintains the host-visible control registers and queues command-word writes for framebuffer control logic over a valid/ready interface.
- Returns a registered read byte for the slave's read path.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on I2C_Data_Ready (minimum 2).
- FIFO_DEPTH, 4, command queue entries (power of 2, 2..16).
- HDL_VERSION, 8'h04, constant value returned for register 1.

Ports:
- MClk  in  1  system clock, 50 MHz
- Rst_n  in  1  asynchronous active-low reset
- I2C_Data_Ready  in  1  write-complete level from I2C slave, asynchronous to MClk
- I2C_Reg_Cmnd  in  8  register index from slave; stable while I2C_Data_Ready high
- I2C_Wr_Data  in  8  written data byte from slave; stable while I2C_Data_Ready high
- I2C_Op_Read  in  1  1 = current transaction is a read
- Status_In  in  8  fabric status, returned as register 3
- Rd_Reg_Data  out  8  registered read value for I2C_Reg_Cmnd
- Reg_Api  out  8  register 0
- Reg_Len  out  8  register 4
- Reg_Clip  out  8  register 5
- Cmd_Valid  out  1  queue head valid
- Cmd_Ready  in  1  consumer accepts head
- Cmd_Code  out  8  head: command byte
- Cmd_Len  out  8  head: Reg_Len snapshot at push
- Cmd_Clip  out  8  head: Reg_Clip snapshot at push
- Cmd_Ovf  out  1  sticky overflow flag
- Wr_Err  out  1  sticky flag: write to a read-only or undefined index
- Clr_Flags  in  1  synchronous clear of Cmd_Ovf and Wr_Err

Behaviour:
- Reset (async assert, sync release):
  - All synchroniser flops 0; FSM to IDLE.
  - Registers 0/2/4/5 = 0; Rd_Reg_Data = 0.
  - FIFO empty: Cmd_Valid = 0, Cmd_Code/Len/Clip = 0.
  - Cmd_Ovf = 0, Wr_Err = 0.
- Synchroniser: I2C_Data_Ready passes through SYNC_STAGES flops to give rdy_s. Only rdy_s is used; the raw input never reaches other logic.
- FSM, three states:
  - IDLE: rdy_s = 1 -> DECODE.
  - DECODE (exactly one cycle): sample I2C_Reg_Cmnd, I2C_Wr_Data and I2C_Op_Read; perform the write action; -> WAIT_LOW.
  - WAIT_LOW: rdy_s = 0 -> IDLE. Guarantees one action per flag pulse, however long the pulse.
- Write action in DECODE, skipped entirely when I2C_Op_Read = 1:
  - Index 0 -> Reg_Api.
  - Index 4 -> Reg_Len.
  - Index 5 -> Reg_Clip.
  - Index 2 -> push {I2C_Wr_Data, Reg_Len, Reg_Clip} into the FIFO. Len/Clip are the values before this cycle.
  - Index 1, 3 or >= 6 -> no register change; set Wr_Err.
- Write latency: register outputs update SYNC_STAGES+1 MClk after the I2C_Data_Ready rise; a pushed command is visible on Cmd_Valid one cycle later.
- FIFO:
  - Show-ahead; Cmd_Valid = not empty.
  - Pop on Cmd_Valid & Cmd_Ready.
  - Push while full and no pop -> entry dropped, Cmd_Ovf set.
  - Push and pop in the same cycle while full -> both performed, occupancy unchanged, no overflow.
  - Push and pop in the same cycle while empty -> push only; the new head appears next cycle.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full when MSBs differ and LSBs are equal.
- Flags: Clr_Flags clears Cmd_Ovf and Wr_Err next cycle. A set event in the same cycle as Clr_Flags wins (flag stays 1).
- Read path: every cycle Rd_Reg_Data <= mux(I2C_Reg_Cmnd):
  - 0 -> Reg_Api
  - 1 -> HDL_VERSION
  - 2 -> last written command byte (register 2 shadow, updated on every index-2 write, including dropped ones)
  - 3 -> Status_In
  - 4 -> Reg_Len
  - 5 -> Reg_Clip
  - other -> 8'h00
  - Latency 1 MClk.
- Reset mid-operation (any state, including DECODE or a partially drained FIFO): all state returns to reset values immediately. A pulse still high at release waits for a full rdy_s low-to-high transition; WAIT_LOW is not entered.

Test Plan:
- Reset, then write idx 4 = 8'h20, idx 5 = 8'h03, idx 2 = 8'hA5 with Cmd_Ready = 0 -> Reg_Len = 20, Reg_Clip = 03; Cmd_Valid = 1 with head {A5, 20, 03}. Raise Cmd_Ready for 1 cycle -> Cmd_Valid = 0.
- Hold I2C_Data_Ready high for 500 cycles with idx 2 = 8'h11 -> exactly one FIFO entry; 3-cycle latency from input rise to register update.
- Cmd_Ready = 0, five idx-2 writes 01..05 (FIFO_DEPTH = 4) -> four entries 01..04 retained, Cmd_Ovf = 1. Clr_Flags -> 0. Simultaneous full push+pop -> occupancy stays 4, Cmd_Ovf stays 0.
- Write idx 1 = 8'hFF and idx 7 = 8'h55 -> Reg_Api/Len/Clip unchanged, Wr_Err = 1, FIFO unchanged. Repeat with I2C_Op_Read = 1 on idx 0 -> no change, Wr_Err not set.
- Read mux: Status_In = 8'h3C, step I2C_Reg_Cmnd 0..7 -> Rd_Reg_Data one cycle later = Reg_Api, 04, last cmd, 3C, Reg_Len, Reg_Clip, 00, 00.
- Assert Rst_n low in DECODE with 2 entries queued -> outputs immediately 0, Cmd_Valid = 0. Release with I2C_Data_Ready still high -> no action until it falls and rises again.
